// File: rtl/axi_pkg.sv
// Shared AXI definitions: the response codes used on the B and R channels.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port word RAM: one byte-enabled write port and one registered,
// read-first read port.
module sdp_ram #(
    parameter int AW        = 14,
    parameter     INIT_FILE = ""
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    wbe,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;
    logic [31:0] rdata_d;

    // The read samples the array before this edge's write lands (read-first).
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= rdata_d;
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (wbe[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi_lite_ram.sv
// AXI4-Lite responder over on-chip RAM: independent AW/W holding registers,
// single-entry B and R response registers, and window decode with SLVERR.
module axi_lite_ram
    import axi_pkg::*;
#(
    parameter int          MEM_AW    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter              INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] axi_awaddr,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam logic [31:0] WIN_BYTES = 32'(4 * (2 ** MEM_AW));

    logic        aw_full_q, aw_full_d;
    logic [31:0] aw_addr_q, aw_addr_d;
    logic        w_full_q,  w_full_d;
    logic [31:0] w_data_q,  w_data_d;
    logic [3:0]  w_strb_q,  w_strb_d;
    logic        bvalid_q,  bvalid_d;
    resp_t       bresp_q,   bresp_d;
    logic        rvalid_q,  rvalid_d;
    resp_t       rresp_q,   rresp_d;

    logic        commit;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;
    logic        aw_in_range;
    logic        ar_in_range;
    logic [31:0] aw_off;
    logic [31:0] ar_off;
    logic        ram_we;
    logic [31:0] ram_rdata;
    logic        unused_ok;

    always_comb begin
        aw_off      = aw_addr_q - BASE_ADDR;
        ar_off      = axi_araddr - BASE_ADDR;
        aw_in_range = aw_off < WIN_BYTES;
        ar_in_range = ar_off < WIN_BYTES;

        // A slot frees in the same cycle it commits, so writes can stream.
        commit      = aw_full_q && w_full_q && (!bvalid_q || axi_bready);
        axi_awready = !aw_full_q || commit;
        axi_wready  = !w_full_q || commit;
        axi_arready = !rvalid_q || axi_rready;

        aw_hs = axi_awvalid && axi_awready;
        w_hs  = axi_wvalid && axi_wready;
        ar_hs = axi_arvalid && axi_arready;

        aw_full_d = aw_full_q;
        aw_addr_d = aw_addr_q;
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_addr_d = axi_awaddr;
        end else if (commit) begin
            aw_full_d = 1'b0;
        end

        w_full_d = w_full_q;
        w_data_d = w_data_q;
        w_strb_d = w_strb_q;
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = axi_wdata;
            w_strb_d = axi_wstrb;
        end else if (commit) begin
            w_full_d = 1'b0;
        end

        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = aw_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (axi_bready) begin
            bvalid_d = 1'b0;
        end

        rvalid_d = rvalid_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (axi_rready) begin
            rvalid_d = 1'b0;
        end

        // A commit coinciding with reset is dropped along with the holding regs.
        ram_we = commit && aw_in_range && !reset;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
        end else begin
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
        end
    end

    always_ff @(posedge clk) begin
        aw_addr_q <= aw_addr_d;
        w_data_q  <= w_data_d;
        w_strb_q  <= w_strb_d;
    end

    sdp_ram #(
        .AW        (MEM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .wbe   (w_strb_q),
        .waddr (aw_off[MEM_AW+1:2]),
        .wdata (w_data_q),
        .re    (ar_hs),
        .raddr (ar_off[MEM_AW+1:2]),
        .rdata (ram_rdata)
    );

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rresp  = rresp_q;
    assign axi_rdata  = (rvalid_q && rresp_q == RESP_OKAY) ? ram_rdata : 32'h0;

    assign unused_ok = ^{axi_awprot, axi_arprot, aw_off[1:0], ar_off[1:0]};

endmodule

// File: tb/tb_axi_lite_ram.sv
// Bench for axi_lite_ram: vector table, hand-written handshake corner cases,
// and randomized traffic checked against a word-array memory model.
module tb_axi_lite_ram;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] axi_awaddr;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    axi_lite_ram #(
        .MEM_AW    (14),
        .BASE_ADDR (32'h0000_0000),
        .INIT_FILE ("")
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .axi_awaddr  (axi_awaddr),
        .axi_awprot  (axi_awprot),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_araddr  (axi_araddr),
        .axi_arprot  (axi_arprot),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] mdl [int];
    logic [13:0] pool [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, b_done = 0, early = 0, aw_hs, w_hs;
        int cyc = 0;
        resp = 2'bxx;
        while (!b_done && cyc < 100) begin
            axi_awaddr  = addr;
            axi_wdata   = data;
            axi_wstrb   = strb;
            axi_awvalid = !aw_done && (cyc >= aw_dly);
            axi_wvalid  = !w_done && (cyc >= w_dly);
            axi_bready  = 1'b1;
            @(negedge clk);
            aw_hs = axi_awvalid && axi_awready;
            w_hs  = axi_wvalid && axi_wready;
            if (axi_bvalid) begin
                if (!(aw_done && w_done)) early = 1;
                resp   = axi_bresp;
                b_done = 1;
            end
            tick();
            aw_done |= aw_hs;
            w_done  |= w_hs;
            cyc++;
        end
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        check("b_timeout", 32'(b_done), 32'd1);
        check("b_before_aw_w", 32'(early), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] addr, input int rdly,
                           output logic [31:0] data, output logic [1:0] resp);
        bit ar_done = 0, r_done = 0, ar_hs;
        int cyc = 0, rv = 0;
        data = 32'hxxxx_xxxx;
        resp = 2'bxx;
        while (!r_done && cyc < 100) begin
            axi_araddr  = addr;
            axi_arvalid = !ar_done;
            axi_rready  = (rv >= rdly);
            @(negedge clk);
            ar_hs = axi_arvalid && axi_arready;
            if (axi_rvalid) begin
                if (axi_rready) begin
                    data   = axi_rdata;
                    resp   = axi_rresp;
                    r_done = 1;
                end else begin
                    rv++;
                end
            end
            tick();
            ar_done |= ar_hs;
            cyc++;
        end
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        check("r_timeout", 32'(r_done), 32'd1);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] word;
        logic [3:0]  strb;
        bit          in_rng;
        int          idx;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 32'h0001_0000, 32'h1234_5678, 4'hF, 2'b10, 32'h0};
        vecs[4]  = '{1'b0, 32'h0001_0000, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[6]  = '{1'b1, 32'h0000_FFFC, 32'hA5A5_A5A5, 4'hF, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_FFFF, 32'h0,         4'h0, 2'b00, 32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'h0, 2'b00, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0011, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'h0, 2'b10, 32'h0};

        reset       = 1'b1;
        axi_awaddr  = '0;
        axi_awprot  = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b1;
        axi_araddr  = '0;
        axi_arprot  = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset
        @(negedge clk);
        check("rst_resp_rdata", {axi_bresp, axi_rresp, axi_rdata[27:0]}, 32'h0);
        tick();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_flags", 32'({axi_awready, axi_wready, axi_arready, axi_bvalid, axi_rvalid}), 32'b11100);
            tick();
        end

        for (int i = 0; i < $size(vecs); i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, resp);
                check($sformatf("vec%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, 0, rd, resp);
                check($sformatf("vec%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            end
        end

        // W leads AW by 5 cycles, then AW leads W by 6 cycles
        do_write(32'h10, 32'h0000_00AA, 4'b0001, 5, 0, resp);
        check("skew_w_first_bresp", 32'(resp), 32'h0);
        do_read(32'h12, 0, rd, resp);
        check("skew_w_first_rdata", rd, 32'hDEAD_BEAA);
        do_write(32'h14, 32'h0102_0304, 4'hF, 0, 6, resp);
        check("skew_aw_first_bresp", 32'(resp), 32'h0);
        do_read(32'h14, 0, rd, resp);
        check("skew_aw_first_rdata", rd, 32'h0102_0304);

        // B backpressure with a second write queued behind it
        axi_bready  = 1'b0;
        axi_awaddr  = 32'h40;
        axi_wdata   = 32'h1111_1111;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        @(negedge clk);
        check("bp_first_accept", 32'({axi_awready, axi_wready}), 32'b11);
        tick();
        axi_awaddr = 32'h44;
        axi_wdata  = 32'h2222_2222;
        @(negedge clk);
        check("bp_second_accept", 32'({axi_awready, axi_wready}), 32'b11);
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_b_stall", 32'({axi_bvalid, axi_bresp, axi_awready, axi_wready}), 32'b10000);
            tick();
        end
        axi_bready = 1'b1;
        @(negedge clk);
        check("bp_b1_valid", 32'(axi_bvalid), 32'd1);
        tick();
        @(negedge clk);
        check("bp_b2_valid", 32'({axi_bvalid, axi_awready}), 32'b11);
        tick();
        @(negedge clk);
        check("bp_b_drained", 32'(axi_bvalid), 32'd0);
        tick();
        do_read(32'h40, 0, rd, resp);
        check("bp_w1_data", rd, 32'h1111_1111);
        do_read(32'h44, 0, rd, resp);
        check("bp_w2_data", rd, 32'h2222_2222);

        // R backpressure with a second read offered
        axi_rready  = 1'b0;
        axi_araddr  = 32'h40;
        axi_arvalid = 1'b1;
        @(negedge clk);
        check("rbp_ar1_ready", 32'(axi_arready), 32'd1);
        tick();
        axi_araddr = 32'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rbp_stall_flags", 32'({axi_arready, axi_rvalid}), 32'b01);
            check("rbp_stall_rdata", axi_rdata, 32'h1111_1111);
            tick();
        end
        axi_rready = 1'b1;
        @(negedge clk);
        check("rbp_release", 32'({axi_arready, axi_rvalid}), 32'b11);
        tick();
        axi_arvalid = 1'b0;
        @(negedge clk);
        check("rbp_r2_data", axi_rdata, 32'h2222_2222);
        check("rbp_r2_valid", 32'(axi_rvalid), 32'd1);
        tick();
        @(negedge clk);
        check("rbp_drained", 32'(axi_rvalid), 32'd0);
        tick();

        // Read in the commit cycle sees old data; the next read sees new data
        do_write(32'h20, 32'h1, 4'hF, 0, 0, resp);
        axi_awaddr  = 32'h20;
        axi_wdata   = 32'h2;
        axi_wstrb   = 4'hF;
        axi_awvalid = 1'b1;
        axi_wvalid  = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        axi_wvalid  = 1'b0;
        axi_araddr  = 32'h20;
        axi_arvalid = 1'b1;
        @(negedge clk);
        check("coll_ar_ready", 32'(axi_arready), 32'd1);
        tick();
        @(negedge clk);
        check("coll_old_data", axi_rdata, 32'h1);
        check("coll_b_valid", 32'(axi_bvalid), 32'd1);
        tick();
        axi_arvalid = 1'b0;
        @(negedge clk);
        check("coll_new_data", axi_rdata, 32'h2);
        tick();
        tick();

        // Reset with AW held and no W: the pending write is dropped
        axi_awaddr  = 32'h24;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        @(negedge clk);
        check("rst_aw_held", 32'(axi_awready), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_after_flags", 32'({axi_awready, axi_wready, axi_bvalid, axi_rvalid}), 32'b1100);
        axi_wdata  = 32'h33;
        axi_wstrb  = 4'hF;
        axi_wvalid = 1'b1;
        tick();
        axi_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_bvalid", 32'(axi_bvalid), 32'd0);
            tick();
        end
        axi_awaddr  = 32'h24;
        axi_awvalid = 1'b1;
        tick();
        axi_awvalid = 1'b0;
        tick();
        @(negedge clk);
        check("rst_late_aw_b", 32'({axi_bvalid, axi_bresp}), 32'b100);
        tick();
        do_read(32'h24, 0, rd, resp);
        check("rst_late_aw_data", rd, 32'h33);
        do_read(32'h20, 0, rd, resp);
        check("rst_committed_kept", rd, 32'h2);

        // Randomized traffic against the word-array model
        for (int i = 0; i < 8; i++) begin
            pool[i] = 14'($urandom_range(16383));
            data    = $urandom;
            do_write({16'h0, pool[i], 2'b00}, data, 4'hF, 0, 0, resp);
            mdl[int'(pool[i])] = data;
        end
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(9) == 0) begin
                addr = $urandom_range(32'hFFFF_FFFF, 32'h0001_0000);
            end else begin
                idx  = int'($urandom_range(7));
                addr = {16'h0, pool[3'(idx)], 2'($urandom_range(3))};
            end
            in_rng = addr < 32'h0001_0000;
            if ($urandom_range(1) == 1) begin
                data = $urandom;
                strb = 4'($urandom_range(15));
                do_write(addr, data, strb, int'($urandom_range(3)), int'($urandom_range(3)), resp);
                check("rand_bresp", 32'(resp), in_rng ? 32'h0 : 32'h2);
                if (in_rng) begin
                    word = mdl[int'(addr >> 2)];
                    for (int b = 0; b < 4; b++) begin
                        if (strb[b]) word[8*b +: 8] = data[8*b +: 8];
                    end
                    mdl[int'(addr >> 2)] = word;
                end
            end else begin
                do_read(addr, int'($urandom_range(2)), rd, resp);
                check("rand_rresp", 32'(resp), in_rng ? 32'h0 : 32'h2);
                check("rand_rdata", rd, in_rng ? mdl[int'(addr >> 2)] : 32'h0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
